// File: rtl/score_display_fmt.sv
// Score/status formatter: iterative double-dabble binary-to-BCD followed by
// a one-cycle format step producing six seven-segment display codes.
module score_display_fmt #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [VALUE_W-1:0]      value,
  input  logic [1:0]              mode,
  output logic [4*NUM_DIGITS-1:0] digit_codes,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  localparam logic [3:0] CodeUnder = 4'hC;
  localparam logic [3:0] CodeE     = 4'hE;
  localparam logic [3:0] CodeBlank = 4'hF;

  typedef enum logic [1:0] {StIdle, StConv, StFormat} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [BCD_W-1:0]        bcd_adj;
  logic [VALUE_W-1:0]      shift_q;
  logic [1:0]              mode_q;
  // Any bit shifted out of the extra digit means the value overflowed even if
  // the digit itself wrapped back to zero (only reachable with wide VALUE_W).
  logic                    lost_q;
  logic [4*NUM_DIGITS-1:0] fmt_codes;
  logic                    fmt_ovf;

  assign busy = (state_q != StIdle);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS) + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    logic lead;
    lead      = 1'b1;
    fmt_ovf   = 1'b0;
    fmt_codes = {NUM_DIGITS{CodeBlank}};
    if (mode_q == 2'd2) begin
      fmt_codes = {NUM_DIGITS{CodeUnder}};
    end else if (mode_q == 2'd3) begin
      fmt_codes = {NUM_DIGITS{CodeBlank}};
    end else if (lost_q || (bcd_q[BCD_W-1 -: 4] != 4'd0)) begin
      fmt_codes = {NUM_DIGITS{CodeUnder}};
      fmt_codes[4*NUM_DIGITS-1 -: 4] = CodeE;
      fmt_ovf = 1'b1;
    end else begin
      // Walk from the most significant digit; digit 0 always shows.
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
        if ((bcd_q[4*i +: 4] != 4'd0) || (i == 0)) lead = 1'b0;
        if (!lead || (mode_q == 2'd1)) fmt_codes[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bcd_q       <= '0;
      shift_q     <= '0;
      mode_q      <= '0;
      lost_q      <= 1'b0;
      digit_codes <= {NUM_DIGITS{CodeBlank}};
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            shift_q <= value;
            mode_q  <= mode;
            bcd_q   <= '0;
            lost_q  <= 1'b0;
            if (!mode[1]) begin
              cnt_q   <= CNT_W'(VALUE_W);
              state_q <= StConv;
            end else begin
              state_q <= StFormat;
            end
          end
        end
        StConv: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
          shift_q <= {shift_q[VALUE_W-2:0], 1'b0};
          lost_q  <= lost_q | bcd_adj[BCD_W-1];
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= StFormat;
        end
        StFormat: begin
          digit_codes <= fmt_codes;
          overflow    <= fmt_ovf;
          done        <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_fmt.sv
// Randomized self-checking bench for score_display_fmt against a decimal
// arithmetic reference model.
module tb_score_display_fmt;

  localparam int unsigned ND = 6;
  localparam int unsigned VW = 20;
  localparam int unsigned CW = 4 * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] digit_codes;
  logic          busy;
  logic          done;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] exp_codes = {CW{1'b1}};
  logic          exp_ovf = 1'b0;

  score_display_fmt #(.NUM_DIGITS(ND), .VALUE_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .mode       (mode),
    .digit_codes(digit_codes),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude comparison.
  task automatic model(input int unsigned v, input logic [1:0] m,
                       output logic [CW-1:0] c, output logic o);
    int unsigned x;
    int unsigned p;
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < int'(ND); i++) lim = lim * 10;
    o = 1'b0;
    c = '0;
    if (m == 2'd2) begin
      for (int i = 0; i < int'(ND); i++) c[4*i +: 4] = 4'hC;
    end else if (m == 2'd3) begin
      for (int i = 0; i < int'(ND); i++) c[4*i +: 4] = 4'hF;
    end else if (v >= lim) begin
      for (int i = 0; i < int'(ND); i++) c[4*i +: 4] = 4'hC;
      c[4*ND-1 -: 4] = 4'hE;
      o = 1'b1;
    end else begin
      x = v;
      p = 1;
      for (int i = 0; i < int'(ND); i++) begin
        c[4*i +: 4] = 4'(x % 10);
        x = x / 10;
        if (m == 2'd0 && i > 0 && v < p) c[4*i +: 4] = 4'hF;
        p = p * 10;
      end
    end
  endtask

  task automatic do_load(input int unsigned v, input logic [1:0] m);
    value = VW'(v);
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    value = VW'($urandom);
    mode  = 2'($urandom);
  endtask

  task automatic wait_result(input string tag, input int exp_busy,
                             input int unsigned v, input logic [1:0] m);
    logic [CW-1:0] c;
    logic          o;
    int            n;
    bit            got;
    model(v, m, c, o);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      if (done) begin
        got = 1'b1;
      end else begin
        check({tag, "_hold"}, 32'(digit_codes), 32'(exp_codes));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    check({tag, "_codes"}, 32'(digit_codes), 32'(c));
    check({tag, "_ovf"}, 32'(overflow), 32'(o));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    exp_codes = c;
    exp_ovf   = o;
  endtask

  task automatic run(input int unsigned v, input logic [1:0] m, input bit b2b);
    string tag;
    tag = $sformatf("v%0d_m%0d", v, m);
    do_load(v, m);
    wait_result(tag, m[1] ? 1 : int'(VW) + 1, v, m);
    if (!b2b) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    bit            saw;
    int unsigned   sel;
    int unsigned   v;
    logic [1:0]    m;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_codes", 32'(digit_codes), 32'hFFFFFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check("idle_codes", 32'(digit_codes), 32'hFFFFFF);
      check("idle_busy", 32'(busy), 32'd0);
    end

    run(1234, 2'd0, 1'b0);
    run(0, 2'd0, 1'b0);
    run(42, 2'd1, 1'b0);
    run(999999, 2'd0, 1'b0);
    run(1000000, 2'd0, 1'b0);
    run(5, 2'd0, 1'b0);
    run(0, 2'd2, 1'b0);
    run(0, 2'd3, 1'b0);
    run(777, 2'd1, 1'b1);
    run(1048575, 2'd0, 1'b0);

    // A load arriving mid-conversion must be dropped.
    do_load(123, 2'd0);
    repeat (4) @(negedge clk);
    value = VW'(7);
    mode  = 2'd1;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_result("ignored_load", int'(VW) + 1 - 5, 123, 2'd0);
    @(negedge clk);

    // Abort a conversion with reset (load held alongside: reset wins).
    run(1000000, 2'd0, 1'b0);
    do_load(456789, 2'd1);
    repeat (9) @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    check("abort_codes", 32'(digit_codes), 32'hFFFFFF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    exp_codes = {CW{1'b1}};
    exp_ovf   = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    check("abort_quiet", 32'(saw), 32'd0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(0, (1 << VW) - 1);
        2:       v = $urandom_range(999990, 1000010);
        default: v = $urandom % (1 << VW);
      endcase
      m = (sel == 3) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      run(v, m, bit'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
